// File: rtl/tc_pl_spi_byte_tx_pkg.sv
// Shared constants and state encoding for the SPI byte transmitter and the
// control-set blocks that feed it.
package tc_pl_spi_byte_tx_pkg;

  localparam int SPI_BITS_DFLT = 8;
  localparam int CLK_DIV_DFLT  = 4;
  localparam int CS_SETUP_DFLT = 2;
  localparam int CS_HOLD_DFLT  = 2;
  localparam int CS_GAP_DFLT   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP
  } spi_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tc_pl_spi_byte_tx_clk_div.sv
// SCLK half-period divider: strobes on the last clk cycle of the low phase
// (rise_stb) and of the high phase (fall_stb); parked in the low phase when idle.
module tc_pl_spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          high;
  logic          last;

  assign last     = (cnt == CW'(CLK_DIV - 1));
  assign rise_stb = en && last && !high;
  assign fall_stb = en && last && high;

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      cnt  <= '0;
      high <= 1'b0;
    end else if (last) begin
      cnt  <= '0;
      high <= ~high;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tc_pl_spi_byte_tx.sv
// Mode-0 SPI master byte transmitter; bytes offered back-to-back at byte
// boundaries share one chip-select frame.
module tc_pl_spi_byte_tx
  import tc_pl_spi_byte_tx_pkg::*;
#(
  parameter int SPI0_0   = SPI_BITS_DFLT,
  parameter int CLK_DIV  = CLK_DIV_DFLT,
  parameter int CS_SETUP = CS_SETUP_DFLT,
  parameter int CS_HOLD  = CS_HOLD_DFLT,
  parameter int CS_GAP   = CS_GAP_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stx_valid,
  input  logic [SPI0_0-1:0] stx_data,
  output logic              stx_dreq,
  output logic              stx_idle,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_cs_n
);

  localparam int BW = (SPI0_0 > 1) ? $clog2(SPI0_0) : 1;
  localparam int TW = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);

  spi_state_t        state, state_nx;
  logic [SPI0_0-1:0] shift_sr, sr_nx;
  logic [BW-1:0]     bit_cnt, bit_nx;
  logic [TW-1:0]     tmr, tmr_nx;
  logic              cs_nx, sclk_nx, dreq_nx, idle_nx;
  logic              rise_stb, fall_stb;
  logic              shift_en;

  assign shift_en = (state == ST_SHIFT);

  tc_pl_spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .rst      (rst),
    .en       (shift_en),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // MOSI is the MSB of the shift register, so it only moves when the register
  // is loaded or shifted, both of which happen as SCLK goes low.
  assign spi_mosi = shift_sr[SPI0_0-1];

  always_comb begin
    state_nx = state;
    sr_nx    = shift_sr;
    bit_nx   = bit_cnt;
    tmr_nx   = tmr;
    cs_nx    = spi_cs_n;
    sclk_nx  = spi_sclk;
    dreq_nx  = 1'b0;
    idle_nx  = stx_idle;

    case (state)
      ST_IDLE: begin
        if (stx_valid) begin
          sr_nx    = stx_data;
          bit_nx   = '0;
          tmr_nx   = '0;
          cs_nx    = 1'b0;
          dreq_nx  = 1'b1;
          idle_nx  = 1'b0;
          state_nx = ST_LEAD;
        end
      end

      ST_LEAD: begin
        if (tmr == TW'(CS_SETUP - 1)) begin
          tmr_nx   = '0;
          state_nx = ST_SHIFT;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end

      ST_SHIFT: begin
        if (rise_stb) begin
          sclk_nx = 1'b1;
        end
        // End of a high phase: either next bit, next byte, or leave the frame.
        if (fall_stb) begin
          sclk_nx = 1'b0;
          if (bit_cnt == BW'(SPI0_0 - 1)) begin
            if (stx_valid) begin
              sr_nx   = stx_data;
              bit_nx  = '0;
              dreq_nx = 1'b1;
            end else begin
              tmr_nx   = '0;
              state_nx = ST_TRAIL;
            end
          end else begin
            sr_nx  = {shift_sr[SPI0_0-2:0], 1'b0};
            bit_nx = bit_cnt + BW'(1);
          end
        end
      end

      ST_TRAIL: begin
        if (tmr == TW'(CS_HOLD - 1)) begin
          tmr_nx   = '0;
          cs_nx    = 1'b1;
          state_nx = ST_GAP;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end

      ST_GAP: begin
        if (tmr == TW'(CS_GAP - 1)) begin
          tmr_nx   = '0;
          idle_nx  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      shift_sr <= '0;
      bit_cnt  <= '0;
      tmr      <= '0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      stx_dreq <= 1'b0;
      stx_idle <= 1'b1;
    end else begin
      state    <= state_nx;
      shift_sr <= sr_nx;
      bit_cnt  <= bit_nx;
      tmr      <= tmr_nx;
      spi_cs_n <= cs_nx;
      spi_sclk <= sclk_nx;
      stx_dreq <= dreq_nx;
      stx_idle <= idle_nx;
    end
  end

endmodule

// File: tb/tb_tc_pl_spi_byte_tx.sv
// Bench for tc_pl_spi_byte_tx: a frame-timeline model predicts every output on
// every cycle, and directed scenarios pin that timeline with literal values.
module tb_tc_pl_spi_byte_tx;

  localparam int NB       = 8;
  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;
  localparam int BYTE_CYC = 2 * CLK_DIV * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stx_valid = 1'b0;
  logic [NB-1:0] stx_data = '0;
  logic          stx_dreq, stx_idle, spi_sclk, spi_mosi, spi_cs_n;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  tc_pl_spi_byte_tx #(
    .SPI0_0   (NB),
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD),
    .CS_GAP   (CS_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stx_valid (stx_valid),
    .stx_data  (stx_data),
    .stx_dreq  (stx_dreq),
    .stx_idle  (stx_idle),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame timeline model: a frame starting at fs with nb bytes has a fixed
  // schedule of LEAD, nb*BYTE_CYC shift cycles, CS hold and CS gap.
  logic          in_frame = 1'b0;
  logic          after_rst = 1'b0;
  int            fs = 0;
  int            nb = 0;
  logic [NB-1:0] mq[$];

  // Observers of the SPI bus and handshake, used by the directed scenarios.
  int            rise_t[$];
  int            dreq_t[$];
  logic [NB-1:0] slave_q[$];
  logic [NB-1:0] slave_sr = '0;
  int            slave_cnt = 0;
  int            cs_fall = 0, cs_rise = 0, idle_rise = 0, last_fall = 0, cs_fall_cnt = 0;
  logic          prev_sclk = 1'b0, prev_cs = 1'b1, prev_idle = 1'b1;

  always @(posedge clk) begin
    int            sh, es, cr, ia, b;
    logic          was_idle, active, exp_mosi;
    logic [NB-1:0] cur;
    cyc++;
    sh = fs + CS_SETUP;
    es = sh + nb * BYTE_CYC;
    ia = es + CS_HOLD + CS_GAP;
    if (!rst) begin
      in_frame  = 1'b0;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      was_idle  = !in_frame || (cyc - 1 >= ia);
      if (was_idle) begin
        in_frame = 1'b0;
        if (stx_valid) begin
          in_frame = 1'b1;
          fs       = cyc;
          nb       = 1;
          mq.delete();
          mq.push_back(stx_data);
        end
      end else if (cyc == es && stx_valid) begin
        mq.push_back(stx_data);
        nb++;
      end
    end
    sh     = fs + CS_SETUP;
    es     = sh + nb * BYTE_CYC;
    cr     = es + CS_HOLD;
    ia     = cr + CS_GAP;
    active = in_frame && (cyc < ia);

    #1;
    checkOutput("cs_n", int'(spi_cs_n), int'(!(active && cyc < cr)));
    checkOutput("sclk", int'(spi_sclk),
                int'(active && cyc >= sh && cyc < es && ((cyc - sh) % (2 * CLK_DIV)) >= CLK_DIV));
    checkOutput("dreq", int'(stx_dreq),
                int'(active && (cyc == fs ||
                     (cyc >= sh + BYTE_CYC && cyc < es && ((cyc - sh) % BYTE_CYC) == 0))));
    checkOutput("idle", int'(stx_idle), int'(!active));
    if (after_rst) begin
      checkOutput("mosi_rst", int'(spi_mosi), 0);
    end else if (active && cyc < es) begin
      b        = (cyc < sh) ? 0 : (cyc - sh) / (2 * CLK_DIV);
      cur      = mq[b / NB];
      exp_mosi = cur[NB - 1 - (b % NB)];
      checkOutput("mosi", int'(spi_mosi), int'(exp_mosi));
    end

    if (spi_sclk && !prev_sclk) begin
      rise_t.push_back(cyc);
      slave_sr = {slave_sr[NB-2:0], spi_mosi};
      slave_cnt++;
      if (slave_cnt == NB) begin
        slave_q.push_back(slave_sr);
        slave_cnt = 0;
      end
    end
    if (!spi_sclk && prev_sclk) last_fall = cyc;
    if (!spi_cs_n && prev_cs) begin
      cs_fall = cyc;
      cs_fall_cnt++;
    end
    if (spi_cs_n && !prev_cs) cs_rise = cyc;
    if (spi_cs_n) slave_cnt = 0;
    if (stx_idle && !prev_idle) idle_rise = cyc;
    if (stx_dreq) dreq_t.push_back(cyc);
    prev_sclk = spi_sclk;
    prev_cs   = spi_cs_n;
    prev_idle = stx_idle;
  end

  logic [NB-1:0] up_q[$];

  task automatic applyStimulus(input logic v, input logic [NB-1:0] d, input logic r);
    @(negedge clk);
    rst       = r;
    stx_valid = v;
    stx_data  = d;
  endtask

  // Upstream byte source: offers the head of up_q and advances on each dreq.
  task automatic run_up(input int n);
    repeat (n) begin
      @(negedge clk);
      if (stx_dreq && up_q.size() > 0) void'(up_q.pop_front());
      stx_valid = (up_q.size() > 0);
      stx_data  = (up_q.size() > 0) ? up_q[0] : '0;
    end
  endtask

  task automatic clear_obs();
    rise_t.delete();
    dreq_t.delete();
    slave_q.delete();
    slave_cnt   = 0;
    cs_fall_cnt = 0;
  endtask

  initial begin
    logic [23:0] dac_value;
    int          pct, rst_hold;
    logic        rv;

    $display("[TB] start");
    repeat (3) applyStimulus(1'b0, '0, 1'b0);
    repeat (4) applyStimulus(1'b0, '0, 1'b1);

    // Single byte 0xA5 with load latency
    clear_obs();
    up_q.delete();
    up_q.push_back(8'hA5);
    applyStimulus(1'b1, 8'hA5, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("load_dreq", int'(stx_dreq), 1);
    checkOutput("load_idle", int'(stx_idle), 0);
    checkOutput("load_cs_n", int'(spi_cs_n), 0);
    checkOutput("load_mosi", int'(spi_mosi), 1);
    run_up(60);
    checkOutput("a5_dreq_cnt", dreq_t.size(), 1);
    checkOutput("a5_edges", rise_t.size(), 8);
    checkOutput("a5_byte", (slave_q.size() == 1) ? int'(slave_q[0]) : -1, 'hA5);
    checkOutput("a5_cs_low", cs_rise - cs_fall, 36);
    checkOutput("a5_idle_after_cs", idle_rise - cs_rise, 4);

    // Three-byte DAC word from the control-set stage, LSB byte first
    clear_obs();
    dac_value = 24'h123456;
    up_q.push_back(dac_value[7:0]);
    up_q.push_back(dac_value[15:8]);
    up_q.push_back(dac_value[23:16]);
    run_up(140);
    checkOutput("dac_cs_frames", cs_fall_cnt, 1);
    checkOutput("dac_edges", rise_t.size(), 24);
    checkOutput("dac_dreq_cnt", dreq_t.size(), 3);
    if (dreq_t.size() >= 3) begin
      checkOutput("dac_dreq_gap01", dreq_t[1] - dreq_t[0], CS_SETUP + BYTE_CYC);
      checkOutput("dac_dreq_gap12", dreq_t[2] - dreq_t[1], 32);
    end
    if (slave_q.size() >= 3) begin
      checkOutput("dac_b0", int'(slave_q[0]), 'h56);
      checkOutput("dac_b1", int'(slave_q[1]), 'h34);
      checkOutput("dac_b2", int'(slave_q[2]), 'h12);
    end else begin
      checkOutput("dac_byte_cnt", slave_q.size(), 3);
    end
    if (rise_t.size() >= 24) begin
      checkOutput("b2b_space_1", rise_t[8] - rise_t[7], 4);
      checkOutput("b2b_space_2", rise_t[16] - rise_t[15], 4);
    end
    checkOutput("dac_cs_hold", cs_rise - last_fall, 2);
    checkOutput("dac_idle_delay", idle_rise - last_fall, 6);

    // stx_valid held into the byte then dropped mid-byte
    clear_obs();
    applyStimulus(1'b1, 8'h3C, 1'b1);
    repeat (9) applyStimulus(1'b1, 8'hFF, 1'b1);
    repeat (60) applyStimulus(1'b0, 8'hFF, 1'b1);
    checkOutput("mid_dreq_cnt", dreq_t.size(), 1);
    checkOutput("mid_edges", rise_t.size(), 8);
    checkOutput("mid_byte", (slave_q.size() == 1) ? int'(slave_q[0]) : -1, 'h3C);
    checkOutput("mid_cs_low", cs_rise - cs_fall, 36);

    // Reset during bit 4 of 0xDB, then a clean frame
    clear_obs();
    up_q.push_back(8'hDB);
    applyStimulus(1'b1, 8'hDB, 1'b1);
    run_up(19);
    applyStimulus(1'b0, '0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("rst_cs_n", int'(spi_cs_n), 1);
    checkOutput("rst_sclk", int'(spi_sclk), 0);
    checkOutput("rst_mosi", int'(spi_mosi), 0);
    checkOutput("rst_idle", int'(stx_idle), 1);
    checkOutput("rst_dreq", int'(stx_dreq), 0);
    checkOutput("rst_edges_before", rise_t.size(), 4);
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rst_dreq_cnt", dreq_t.size(), 1);
    checkOutput("rst_no_byte", slave_q.size(), 0);
    up_q.push_back(8'h81);
    run_up(60);
    checkOutput("post_rst_byte", (slave_q.size() == 1) ? int'(slave_q[0]) : -1, 'h81);
    checkOutput("post_rst_cs_low", cs_rise - cs_fall, 36);
    checkOutput("post_rst_dreq_cnt", dreq_t.size(), 2);

    // Randomized traffic with occasional resets
    pct      = 50;
    rst_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 128) == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 0;
          1: pct = 10;
          2: pct = 50;
          default: pct = 95;
        endcase
      end
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 399) == 0) rst_hold = $urandom_range(1, 3);
      rv = ($urandom_range(0, 99) < pct);
      applyStimulus(rv, NB'($urandom_range(0, 255)), (rst_hold == 0));
    end
    repeat (10) applyStimulus(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
